// File: rtl/tile_capture.sv
// Copies one TILE x TILE block of the framebuffer into tile RAM in raster order.
// Reads are issued one per cycle; each write lands one cycle later, once fb_q is valid.
module tile_capture #(
  parameter int TILE   = 20,
  parameter int GRID_W = 8,
  parameter int GRID_H = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] grid_x,
  input  logic [3:0] grid_y,
  output logic [7:0] fb_x,
  output logic [6:0] fb_y,
  input  logic [8:0] fb_q,
  output logic [8:0] tile_addr,
  output logic [8:0] tile_data,
  output logic       tile_wren,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int             LW     = $clog2(TILE);
  localparam logic [LW-1:0]  L_LAST = LW'(TILE - 1);
  localparam logic [8:0]     TILE_A = 9'(TILE);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [LW-1:0] lx_reg, lx_next;
  logic [LW-1:0] ly_reg, ly_next;
  logic [3:0]    gx_reg, gx_next;
  logic [3:0]    gy_reg, gy_next;
  logic [7:0]    fb_x_reg, fb_x_next;
  logic [6:0]    fb_y_reg, fb_y_next;
  logic          pipe_valid_reg, pipe_valid_next;
  logic [8:0]    pipe_idx_reg, pipe_idx_next;
  logic          error_reg, error_next;

  logic [7:0] base_x;
  logic       in_range;
  logic       row_end;
  logic       last_read;

  assign base_x    = 8'(gx_reg * TILE);
  assign in_range  = (grid_x < 4'(GRID_W)) && (grid_y < 4'(GRID_H));
  assign row_end   = (lx_reg == L_LAST);
  assign last_read = row_end && (ly_reg == L_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      lx_reg         <= '0;
      ly_reg         <= '0;
      gx_reg         <= '0;
      gy_reg         <= '0;
      fb_x_reg       <= '0;
      fb_y_reg       <= '0;
      pipe_valid_reg <= 1'b0;
      pipe_idx_reg   <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lx_reg         <= lx_next;
      ly_reg         <= ly_next;
      gx_reg         <= gx_next;
      gy_reg         <= gy_next;
      fb_x_reg       <= fb_x_next;
      fb_y_reg       <= fb_y_next;
      pipe_valid_reg <= pipe_valid_next;
      pipe_idx_reg   <= pipe_idx_next;
      error_reg      <= error_next;
    end
  end

  // The read address registers are loaded on the accepting edge so the first
  // READ cycle already presents the tile origin; afterwards they step incrementally.
  always_comb begin
    state_next      = state_reg;
    lx_next         = lx_reg;
    ly_next         = ly_reg;
    gx_next         = gx_reg;
    gy_next         = gy_reg;
    fb_x_next       = fb_x_reg;
    fb_y_next       = fb_y_reg;
    pipe_valid_next = 1'b0;
    pipe_idx_next   = pipe_idx_reg;
    error_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (in_range) begin
            gx_next    = grid_x;
            gy_next    = grid_y;
            lx_next    = '0;
            ly_next    = '0;
            fb_x_next  = 8'(grid_x * TILE);
            fb_y_next  = 7'(grid_y * TILE);
            state_next = READ;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      READ: begin
        pipe_valid_next = 1'b1;
        pipe_idx_next   = 9'(ly_reg) * TILE_A + 9'(lx_reg);
        if (last_read) begin
          state_next = DRAIN;
        end else if (row_end) begin
          lx_next   = '0;
          ly_next   = ly_reg + LW'(1);
          fb_x_next = base_x;
          fb_y_next = fb_y_reg + 7'd1;
        end else begin
          lx_next   = lx_reg + LW'(1);
          fb_x_next = fb_x_reg + 8'd1;
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fb_x      = fb_x_reg;
  assign fb_y      = fb_y_reg;
  assign tile_wren = pipe_valid_reg;
  assign tile_addr = pipe_idx_reg;
  // Gated so the write data reads as zero whenever no write is in flight.
  assign tile_data = pipe_valid_reg ? fb_q : 9'd0;
  assign busy      = (state_reg == READ) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);
  assign error     = error_reg;

endmodule

// File: tb/tb_tile_capture.sv
// Randomized bench for tile_capture: a framebuffer model answers reads with one
// cycle of latency and every cycle of each capture is checked against expected pixels.
module tb_tile_capture;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] grid_x;
  logic [3:0] grid_y;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic [8:0] fb_q = 9'd0;
  logic [8:0] tile_addr;
  logic [8:0] tile_data;
  logic       tile_wren;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  logic [8:0] fbmem [0:19199];

  tile_capture dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .grid_x    (grid_x),
    .grid_y    (grid_y),
    .fb_x      (fb_x),
    .fb_y      (fb_y),
    .fb_q      (fb_q),
    .tile_addr (tile_addr),
    .tile_data (tile_data),
    .tile_wren (tile_wren),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer: data for an address appears one cycle later.
  always @(posedge clk)
    fb_q <= (fb_x < 8'd160 && fb_y < 7'd120) ? fbmem[int'(fb_y) * 160 + int'(fb_x)] : 9'd0;

  function automatic logic [31:0] pix(input int x, input int y);
    return 32'(fbmem[y * 160 + x]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_wren", tile_wren, 0);
    end
  endtask

  // Drives start in IDLE and returns at the negedge of the first READ cycle.
  task automatic start_cap(input int gx, input int gy, input bit hold);
    start  = 1'b1;
    grid_x = 4'(gx);
    grid_y = 4'(gy);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Checks cycles R0..R0+401; optionally aborts with reset during cycle R0+abort_at.
  task automatic follow(input int gx, input int gy, input int abort_at, input bit jitter);
    int ox = gx * 20;
    int oy = gy * 20;
    for (int c = 0; c <= 401; c++) begin
      check("busy", busy, 32'(c <= 400));
      check("done", done, 32'(c == 401));
      check("error", error, 0);
      check("wren", tile_wren, 32'(c >= 1 && c <= 400));
      if (c <= 399) begin
        check("fb_x", fb_x, 32'(ox + c % 20));
        check("fb_y", fb_y, 32'(oy + c / 20));
      end else begin
        check("fb_x_hold", fb_x, 32'(ox + 19));
        check("fb_y_hold", fb_y, 32'(oy + 19));
      end
      if (c >= 1 && c <= 400) begin
        check("tile_addr", tile_addr, 32'(c - 1));
        check("tile_data", tile_data, pix(ox + (c - 1) % 20, oy + (c - 1) / 20));
      end
      if (c == abort_at) begin
        resetn = 1'b0;
        @(negedge clk);
        check("abort_wren", tile_wren, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_fb_x", fb_x, 0);
        check("abort_fb_y", fb_y, 0);
        check("abort_addr", tile_addr, 0);
        check("abort_data", tile_data, 0);
        resetn = 1'b1;
        idle_check(5);
        $display("capture gx=%0d gy=%0d aborted at R0+%0d errors=%0d", gx, gy, c, errors);
        return;
      end
      if (jitter) begin
        grid_x = 4'($urandom_range(0, 15));
        grid_y = 4'($urandom_range(0, 15));
      end
      if (c < 401) @(negedge clk);
    end
    $display("capture gx=%0d gy=%0d complete errors=%0d", gx, gy, errors);
  endtask

  task automatic bad_start(input int gx, input int gy);
    start  = 1'b1;
    grid_x = 4'(gx);
    grid_y = 4'(gy);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", error, 1);
    check("err_busy", busy, 0);
    check("err_wren", tile_wren, 0);
    @(negedge clk);
    check("err_clear", error, 0);
    check("err_busy2", busy, 0);
    check("err_wren2", tile_wren, 0);
    $display("reject gx=%0d gy=%0d errors=%0d", gx, gy, errors);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        fbmem[y * 160 + x] = 9'((y * 160 + x) % 512);

    resetn = 1'b0;
    start  = 1'b0;
    grid_x = 4'd0;
    grid_y = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wren", tile_wren, 0);
    check("rst_fb_x", fb_x, 0);
    check("rst_fb_y", fb_y, 0);
    check("rst_addr", tile_addr, 0);
    check("rst_data", tile_data, 0);
    resetn = 1'b1;
    idle_check(2);

    start_cap(0, 0, 0); follow(0, 0, -1, 0); idle_check(3);
    start_cap(7, 5, 0); follow(7, 5, -1, 0); idle_check(3);

    bad_start(8, 0);
    bad_start(0, 6);
    bad_start($urandom_range(8, 15), $urandom_range(0, 15));

    // Start held across the whole capture: a second one begins right after DONE.
    start_cap(3, 2, 1);
    follow(3, 2, -1, 0);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    check("hold_idle_wren", tile_wren, 0);
    @(negedge clk);
    start = 1'b0;
    follow(3, 2, -1, 0);
    idle_check(4);

    start_cap(4, 1, 0); follow(4, 1, 150, 0);
    start_cap(4, 1, 0); follow(4, 1, -1, 0); idle_check(2);

    start_cap(2, 3, 0); follow(2, 3, -1, 1); idle_check(2);

    for (int i = 0; i < 19200; i++) fbmem[i] = 9'($urandom_range(0, 511));
    for (int n = 0; n < 4; n++) begin
      int gx = $urandom_range(0, 7);
      int gy = $urandom_range(0, 5);
      start_cap(gx, gy, 0);
      follow(gx, gy, -1, 0);
      idle_check($urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_capture.md
TILE_CAPTURE -- requirements
Module: tile_capture

Interface
REQ-001 Parameter: TILE, 20, tile edge in pixels (square tile, TILE*TILE words).
REQ-002 Parameter: GRID_W, 8, tile columns on the 160-pixel-wide screen.
REQ-003 Parameter: GRID_H, 6, tile rows on the 120-pixel-high screen.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: resetn  in  1  synchronous, active-low reset.
REQ-006 Port: start  in  1  capture request, sampled only in IDLE.
REQ-007 Port: grid_x  in  4  tile column index, latched at accepted start.
REQ-008 Port: grid_y  in  4  tile row index, latched at accepted start.
REQ-009 Port: fb_x  out  8  framebuffer read column.
REQ-010 Port: fb_y  out  7  framebuffer read row.
REQ-011 Port: fb_q  in  9  framebuffer read data, valid exactly 1 cycle after fb_x/fb_y.
REQ-012 Port: tile_addr  out  9  tile RAM write address.
REQ-013 Port: tile_data  out  9  tile RAM write data.
REQ-014 Port: tile_wren  out  1  tile RAM write enable.
REQ-015 Port: busy  out  1  high while a capture is in progress.
REQ-016 Port: done  out  1  one-cycle pulse at capture completion.
REQ-017 Port: error  out  1  one-cycle pulse on a rejected start.

Function
REQ-018 The block SHALL copy one TILE x TILE region of the framebuffer, at pixel origin (grid_x*TILE, grid_y*TILE), into tile RAM words 0..TILE*TILE-1.
REQ-019 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-020 IDLE: start=1 with grid_x<GRID_W and grid_y<GRID_H SHALL latch the grid indices, clear the local counters lx and ly, and go to READ.
REQ-021 IDLE: start=1 with an out-of-range index SHALL pulse error for 1 cycle, issue no writes, and remain in IDLE.
REQ-022 READ: each cycle SHALL present fb_x=gx*TILE+lx and fb_y=gy*TILE+ly, then advance lx; at lx=TILE-1, lx SHALL wrap to 0 and ly SHALL increment (raster order, x fastest).
REQ-023 Read index i=ly*TILE+lx SHALL be issued in cycle R0+i for i=0..399, where R0 is the first READ cycle.
REQ-024 A pipeline register SHALL hold the index and valid flag of the read issued in the previous cycle; when valid, tile_wren=1, tile_addr=that index and tile_data=fb_q.
REQ-025 The write of index i SHALL occur in cycle R0+1+i, with no gaps and exactly 400 writes per capture.
REQ-026 After issuing index 399, the FSM SHALL go to DRAIN for 1 cycle, where the final write of index 399 occurs, then go to DONE.
REQ-027 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE; a start in DONE SHALL be ignored.
REQ-028 busy SHALL be 1 in READ and DRAIN (cycles R0..R0+400) and 0 otherwise.
REQ-029 start SHALL be ignored in READ, DRAIN and DONE; latched grid indices SHALL NOT change mid-capture.
REQ-030 tile_addr SHALL be computed as ly*TILE+lx in 9 bits, with maximum value 399 and no overflow.
REQ-031 fb_x SHALL stay <= 159 and fb_y <= 119 for all accepted starts.
REQ-032 tile_wren SHALL be 0 in IDLE and DONE.
REQ-033 Outside READ, fb_x and fb_y SHALL hold their last value.

Reset
REQ-034 resetn=0 at a clock edge SHALL force IDLE and clear lx, ly, the pipeline valid flag, busy, done, error and tile_wren to 0.
REQ-035 resetn=0 at a clock edge SHALL clear fb_x, fb_y, tile_addr and tile_data to 0.
REQ-036 Reset asserted mid-capture SHALL abort the capture with no further writes from the next cycle onward and no done pulse.

Verification
REQ-037 Scenario: start with grid (0,0), framebuffer pattern colour=(y*160+x) mod 512 -> 400 writes with addr i and data equal to pixel (i mod 20, i/20); done at R0+401.
REQ-038 Scenario: start with grid (7,5) -> first read at (140,100), last read at (159,119); tile_addr 399 holds pixel (159,119).
REQ-039 Scenario: start with grid (8,0), then with grid (0,6) -> error pulses once for each, busy stays 0, no tile_wren.
REQ-040 Scenario: start held high for the whole capture -> exactly one capture; a new capture begins at the first IDLE cycle after DONE.
REQ-041 Scenario: resetn low at R0+150 -> tile_wren=0 from the next cycle, busy=0, no done pulse; a new start then recaptures from index 0.
REQ-042 Scenario: grid_x/grid_y changed during READ -> addresses continue to use the latched indices.
